// File: rtl/tl_if.sv
// TileLink-UL A/D channel bundle between one requester and one responder.
interface tl_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SID_WIDTH = 2
);
    logic                 a_valid;
    logic                 a_ready;
    logic [2:0]           a_opcode;
    logic [2:0]           a_param;
    logic [2:0]           a_size;
    logic [SID_WIDTH-1:0] a_source;
    logic [XLEN-1:0]      a_address;
    logic [XLEN/8-1:0]    a_mask;
    logic [XLEN-1:0]      a_data;

    logic                 d_valid;
    logic                 d_ready;
    logic [2:0]           d_opcode;
    logic [1:0]           d_param;
    logic [2:0]           d_size;
    logic [SID_WIDTH-1:0] d_source;
    logic [XLEN-1:0]      d_data;
    logic                 d_corrupt;
    logic                 d_denied;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output d_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  d_ready,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied
    );
endinterface

// File: rtl/tl_ram.sv
// Single-port TileLink-UL slave RAM with one outstanding request and a
// registered one-cycle response.
module tl_ram #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SID_WIDTH = 2,
    parameter int unsigned SIZE      = 65520
) (
    input logic clk,
    input logic reset,
    tl_if.slave tl
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned LSB   = $clog2(LANES);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    // Byte storage; left unreset so benches can preload it through the hierarchy.
    logic [7:0] memory [2**WIDTH];

    state_e          state_q;
    logic            fire;
    logic            is_get;
    logic            is_put;
    logic            op_ok;
    logic            size_ok;
    logic            align_ok;
    logic            range_ok;
    logic            denied;
    logic [XLEN-1:0] size_bytes;
    logic [XLEN:0]   end_addr;
    logic [WIDTH-1:0] base;
    logic [XLEN-1:0] rdata;
    logic            unused_param;

    assign unused_param = ^tl.a_param;

    assign fire   = tl.a_valid && tl.a_ready && !reset;
    assign is_get = (tl.a_opcode == OpGet);
    assign is_put = (tl.a_opcode == OpPutFull) || (tl.a_opcode == OpPutPartial);
    assign op_ok  = is_get || is_put;

    // Size is checked first, so the wide shift below only matters for legal sizes.
    assign size_ok    = (tl.a_size <= 3'(LSB));
    assign size_bytes = XLEN'(1) << tl.a_size;
    assign align_ok   = ((tl.a_address & (size_bytes - XLEN'(1))) == '0);
    assign end_addr   = {1'b0, tl.a_address} + {1'b0, size_bytes};
    assign range_ok   = (end_addr <= (XLEN + 1)'(SIZE));
    assign denied     = !(op_ok && size_ok && align_ok && range_ok);

    assign base = {tl.a_address[WIDTH-1:LSB], {LSB{1'b0}}};

    // Lane-aligned read of the addressed word, unmasked lanes forced to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (tl.a_mask[i]) begin
                rdata[8*i +: 8] = memory[base + WIDTH'(i)];
            end
        end
    end

    // Byte-lane writes land on the accept edge so a following Get sees them.
    always_ff @(posedge clk) begin
        if (fire && is_put && !denied) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (tl.a_mask[i]) begin
                    memory[base + WIDTH'(i)] <= tl.a_data[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM; every channel output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tl.a_ready   <= 1'b0;
            tl.d_valid   <= 1'b0;
            tl.d_opcode  <= '0;
            tl.d_param   <= '0;
            tl.d_size    <= '0;
            tl.d_source  <= '0;
            tl.d_data    <= '0;
            tl.d_corrupt <= 1'b0;
            tl.d_denied  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tl.a_ready <= 1'b1;
                    if (fire) begin
                        state_q     <= StResp;
                        tl.a_ready  <= 1'b0;
                        tl.d_valid  <= 1'b1;
                        tl.d_opcode <= is_get ? OpAccessAckData : OpAccessAck;
                        tl.d_size   <= tl.a_size;
                        tl.d_source <= tl.a_source;
                        tl.d_data   <= (is_get && !denied) ? rdata : '0;
                        tl.d_denied <= denied;
                    end
                end
                StResp: begin
                    if (tl.d_ready) begin
                        state_q    <= StIdle;
                        tl.d_valid <= 1'b0;
                        tl.a_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_ram.sv
// Directed bench for tl_ram: preload, reads, writes, backpressure, denials, reset.
module tb_tl_ram;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] r_data;
    logic [2:0]  r_opcode;
    logic [2:0]  r_size;
    logic [1:0]  r_source;
    logic        r_denied;

    tl_if #(.XLEN(32), .SID_WIDTH(2)) tl ();

    tl_ram #(.XLEN(32), .WIDTH(16), .SID_WIDTH(2), .SIZE(65520)) dut (
        .clk   (clk),
        .reset (reset),
        .tl    (tl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Wait for a_ready, issue one request, and capture the response one cycle later.
    task automatic tl_req(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic [1:0] src);
        int n = 0;
        while (tl.a_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("a_ready_wait", 32'(tl.a_ready), 32'd1);
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_size    = sz;
        tl.a_address = addr;
        tl.a_mask    = mask;
        tl.a_data    = data;
        tl.a_source  = src;
        @(posedge clk);
        #1;
        tl.a_valid = 1'b0;
        check("d_latency", 32'(tl.d_valid), 32'd1);
        check("a_ready_busy", 32'(tl.a_ready), 32'd0);
        r_data   = tl.d_data;
        r_opcode = tl.d_opcode;
        r_size   = tl.d_size;
        r_source = tl.d_source;
        r_denied = tl.d_denied;
    endtask

    // With d_ready high the response retires on the next edge.
    task automatic tl_done();
        @(posedge clk);
        #1;
        check("d_valid_fall", 32'(tl.d_valid), 32'd0);
        check("a_ready_rise", 32'(tl.a_ready), 32'd1);
    endtask

    task automatic get_word(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] exp);
        tl_req(3'd4, 3'd2, addr, mask, 32'h0, 2'd3);
        check(tag, r_data, exp);
        check({tag, "_op"}, 32'(r_opcode), 32'd1);
        check({tag, "_den"}, 32'(r_denied), 32'd0);
        tl_done();
    endtask

    task automatic expect_denied(input string tag, input logic [2:0] op, input logic [2:0] sz,
                                 input logic [31:0] addr, input logic [2:0] exp_op);
        tl_req(op, sz, addr, 4'hF, 32'h99887766, 2'd1);
        check({tag, "_den"}, 32'(r_denied), 32'd1);
        check({tag, "_data"}, r_data, 32'h0);
        check({tag, "_op"}, 32'(r_opcode), 32'(exp_op));
        tl_done();
    endtask

    initial begin
        tl.a_valid   = 1'b0;
        tl.a_opcode  = 3'd0;
        tl.a_param   = 3'd0;
        tl.a_size    = 3'd0;
        tl.a_source  = 2'd0;
        tl.a_address = 32'h0;
        tl.a_mask    = 4'h0;
        tl.a_data    = 32'h0;
        tl.d_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        dut.memory[16'h0000] = 8'h13;
        dut.memory[16'h0001] = 8'h05;
        dut.memory[16'h0002] = 8'hA0;
        dut.memory[16'h0003] = 8'h00;
        dut.memory[16'h0100] = 8'h11;
        dut.memory[16'h0101] = 8'h22;
        dut.memory[16'h0102] = 8'h33;
        dut.memory[16'h0103] = 8'h44;
        dut.memory[16'hFF06] = 8'h00;
        dut.memory[16'hFF07] = 8'h00;
        dut.memory[16'hFFEC] = 8'hEF;
        dut.memory[16'hFFED] = 8'hBE;
        dut.memory[16'hFFEE] = 8'hAD;
        dut.memory[16'hFFEF] = 8'hDE;
        dut.memory[16'hFFF0] = 8'h5A;
        @(posedge clk);
        #1;
        check("rst_d_valid", 32'(tl.d_valid), 32'd0);
        check("rst_a_ready", 32'(tl.a_ready), 32'd0);
        check("rst_d_data", tl.d_data, 32'h0);
        check("rst_d_denied", 32'(tl.d_denied), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_a_ready", 32'(tl.a_ready), 32'd1);

        // Preloaded word, source and size echoed.
        tl_req(3'd4, 3'd2, 32'h0, 4'hF, 32'h0, 2'd2);
        check("preload_data", r_data, 32'h00A00513);
        check("preload_op", 32'(r_opcode), 32'd1);
        check("preload_den", 32'(r_denied), 32'd0);
        check("preload_src", 32'(r_source), 32'd2);
        check("preload_size", 32'(r_size), 32'd2);
        tl_done();

        // Single byte write into lane 2.
        tl_req(3'd1, 3'd0, 32'h102, 4'b0100, 32'h00AB0000, 2'd1);
        check("pbyte_op", 32'(r_opcode), 32'd0);
        check("pbyte_den", 32'(r_denied), 32'd0);
        check("pbyte_data", r_data, 32'h0);
        check("pbyte_src", 32'(r_source), 32'd1);
        tl_done();
        get_word("rd_100", 32'h100, 4'hF, 32'h44AB2211);
        get_word("rd_100_lo", 32'h100, 4'b0011, 32'h00002211);

        // Half-word write near the top, then the last legal word.
        tl_req(3'd0, 3'd1, 32'hFF04, 4'b0011, 32'h00001234, 2'd0);
        check("phalf_den", 32'(r_denied), 32'd0);
        tl_done();
        check("mem_ff04", 32'(dut.memory[16'hFF04]), 32'h34);
        check("mem_ff05", 32'(dut.memory[16'hFF05]), 32'h12);
        get_word("rd_ff04", 32'hFF04, 4'hF, 32'h00001234);
        get_word("rd_ffec", 32'hFFEC, 4'hF, 32'hDEADBEEF);

        // Backpressure: response held steady for five cycles.
        tl.d_ready = 1'b0;
        tl_req(3'd4, 3'd2, 32'h100, 4'hF, 32'h0, 2'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_d_valid", 32'(tl.d_valid), 32'd1);
            check("bp_d_data", tl.d_data, 32'h44AB2211);
            check("bp_a_ready", 32'(tl.a_ready), 32'd0);
        end
        tl.d_ready = 1'b1;
        tl_done();

        // Denials leave memory untouched.
        expect_denied("den_range_get", 3'd4, 3'd2, 32'hFFF0, 3'd1);
        expect_denied("den_range_put", 3'd0, 3'd2, 32'hFFF0, 3'd0);
        check("mem_fff0", 32'(dut.memory[16'hFFF0]), 32'h5A);
        expect_denied("den_misalign", 3'd4, 3'd2, 32'h3, 3'd1);
        expect_denied("den_misalign_put", 3'd0, 3'd1, 32'h101, 3'd0);
        expect_denied("den_opcode", 3'd2, 3'd2, 32'h100, 3'd0);
        expect_denied("den_size", 3'd4, 3'd3, 32'h0, 3'd1);
        get_word("rd_100_after_den", 32'h100, 4'hF, 32'h44AB2211);

        // Reset while a write response is pending.
        tl.d_ready = 1'b0;
        tl_req(3'd0, 3'd2, 32'h200, 4'hF, 32'hCAFEF00D, 2'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_d_valid", 32'(tl.d_valid), 32'd0);
        check("mid_rst_a_ready", 32'(tl.a_ready), 32'd0);
        check("mid_rst_d_source", 32'(tl.d_source), 32'd0);
        reset = 1'b0;
        tl.d_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_a_ready_back", 32'(tl.a_ready), 32'd1);
        get_word("rd_200", 32'h200, 4'hF, 32'hCAFEF00D);
        get_word("rd_0_kept", 32'h0, 4'hF, 32'h00A00513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
